// File: rtl/pwm_demodulator_if.sv
// pwm_demodulator_if
//   Groups the PWM input and the measurement results of pwm_demodulator.
//   master : PWM source / result consumer (drives pwm_in, reads results)
//   slave  : the demodulator (reads pwm_in, drives results)
//   Signals: pwm_in, duty[MOD_WIDTH], high_cnt[CNT_WIDTH], period_cnt[CNT_WIDTH],
//            duty_valid, busy, timeout, overrun.
interface pwm_demodulator_if #(
    parameter int CNT_WIDTH = 16,
    parameter int MOD_WIDTH = 8
);
    logic                 pwm_in;
    logic [MOD_WIDTH-1:0] duty;
    logic [CNT_WIDTH-1:0] high_cnt;
    logic [CNT_WIDTH-1:0] period_cnt;
    logic                 duty_valid;
    logic                 busy;
    logic                 timeout;
    logic                 overrun;

    modport master (
        output pwm_in,
        input  duty, high_cnt, period_cnt, duty_valid, busy, timeout, overrun
    );

    modport slave (
        input  pwm_in,
        output duty, high_cnt, period_cnt, duty_valid, busy, timeout, overrun
    );
endinterface

// File: rtl/pwm_demodulator.sv
// pwm_demodulator
//   Measures an active-high PWM waveform in clk cycles. Each accepted period
//   reports the high time, the period length and a normalized duty value
//   floor(high * 2^MOD_WIDTH / period) from a bit-serial restoring divider.
//   A line stuck for 2^CNT_WIDTH-1 cycles raises a timeout level.
//   Ports:
//     clk   - system clock
//     nrst  - asynchronous active-low reset
//     bus   - pwm_demodulator_if.slave (pwm_in in; duty, high_cnt, period_cnt,
//             duty_valid, busy, timeout, overrun out; all outputs registered)
module pwm_demodulator #(
    parameter int CNT_WIDTH = 16,
    parameter int MOD_WIDTH = 8
) (
    input  logic               clk,
    input  logic               nrst,
    pwm_demodulator_if.slave   bus
);
    localparam int BIT_W = (MOD_WIDTH > 1) ? $clog2(MOD_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cap_h_q, cap_h_d;
    logic                 armed_q, armed_d;
    logic [CNT_WIDTH:0]   rem_q, rem_d;
    logic [CNT_WIDTH-1:0] div_p_q, div_p_d, div_h_q, div_h_d;
    logic [MOD_WIDTH-1:0] quot_q, quot_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [MOD_WIDTH-1:0] duty_q, duty_d;
    logic [CNT_WIDTH-1:0] high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
    logic                 duty_valid_q, duty_valid_d, busy_q, busy_d;
    logic                 timeout_q, timeout_d, overrun_q, overrun_d;

    logic                 rise_s, fall_s, ge_s;
    logic [CNT_WIDTH:0]   rem_dbl_s, p_ext_s, rem_step_s;
    logic [MOD_WIDTH-1:0] quot_step_s;

    // Next-state, divider step and output computation
    always_comb begin
        state_d      = state_q;
        sync1_d      = bus.pwm_in;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        cnt_d        = cnt_q;
        cap_h_d      = cap_h_q;
        armed_d      = armed_q;
        rem_d        = rem_q;
        div_p_d      = div_p_q;
        div_h_d      = div_h_q;
        quot_d       = quot_q;
        bit_d        = bit_q;
        duty_d       = duty_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        duty_valid_d = 1'b0;
        timeout_d    = timeout_q;
        overrun_d    = 1'b0;

        rise_s = sync2_q & ~prev_q;
        fall_s = ~sync2_q & prev_q;

        // Remainder stays below P, so doubling never overflows CNT_WIDTH+1 bits.
        rem_dbl_s   = rem_q << 1;
        p_ext_s     = {1'b0, div_p_q};
        ge_s        = (rem_dbl_s >= p_ext_s);
        rem_step_s  = ge_s ? (rem_dbl_s - p_ext_s) : rem_dbl_s;
        quot_step_s = quot_q;
        quot_step_s[bit_q] = ge_s;

        if (rise_s) begin
            cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end

        if (fall_s) begin
            cap_h_d = cnt_q;
        end else begin
            cap_h_d = cap_h_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise_s && armed_q) begin
                    rem_d   = {1'b0, cap_h_q};
                    div_h_d = cap_h_q;
                    div_p_d = cnt_q;
                    quot_d  = {MOD_WIDTH{1'b0}};
                    bit_d   = BIT_W'(MOD_WIDTH - 1);
                    state_d = ST_DIV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                rem_d  = rem_step_s;
                quot_d = quot_step_s;
                // Results are registered on the last step so they are
                // visible exactly while the FSM sits in DONE.
                if (bit_q == {BIT_W{1'b0}}) begin
                    state_d      = ST_DONE;
                    duty_d       = quot_step_s;
                    high_cnt_d   = div_h_q;
                    period_cnt_d = div_p_q;
                    duty_valid_d = 1'b1;
                end else begin
                    bit_d = bit_q - {{(BIT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        overrun_d = rise_s && armed_q && (state_q != ST_IDLE);

        // The divider is always idle here: a timeout needs far more cycles
        // than a division takes.
        if (rise_s) begin
            armed_d   = 1'b1;
            timeout_d = 1'b0;
        end else if (armed_q && (cnt_q == CNT_MAX)) begin
            armed_d      = 1'b0;
            timeout_d    = 1'b1;
            duty_d       = sync2_q ? {MOD_WIDTH{1'b1}} : {MOD_WIDTH{1'b0}};
            duty_valid_d = 1'b1;
        end else begin
            armed_d   = armed_q;
            timeout_d = timeout_q;
        end

        busy_d = (state_d == ST_DIV);
    end

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Synchronizer, counter, divider datapath and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            cnt_q        <= {CNT_WIDTH{1'b0}};
            cap_h_q      <= {CNT_WIDTH{1'b0}};
            armed_q      <= 1'b0;
            rem_q        <= {(CNT_WIDTH+1){1'b0}};
            div_p_q      <= {CNT_WIDTH{1'b0}};
            div_h_q      <= {CNT_WIDTH{1'b0}};
            quot_q       <= {MOD_WIDTH{1'b0}};
            bit_q        <= {BIT_W{1'b0}};
            duty_q       <= {MOD_WIDTH{1'b0}};
            high_cnt_q   <= {CNT_WIDTH{1'b0}};
            period_cnt_q <= {CNT_WIDTH{1'b0}};
            duty_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            cap_h_q      <= cap_h_d;
            armed_q      <= armed_d;
            rem_q        <= rem_d;
            div_p_q      <= div_p_d;
            div_h_q      <= div_h_d;
            quot_q       <= quot_d;
            bit_q        <= bit_d;
            duty_q       <= duty_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            duty_valid_q <= duty_valid_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.duty       = duty_q;
    assign bus.high_cnt   = high_cnt_q;
    assign bus.period_cnt = period_cnt_q;
    assign bus.duty_valid = duty_valid_q;
    assign bus.busy       = busy_q;
    assign bus.timeout    = timeout_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_pwm_demodulator.sv
// tb_pwm_demodulator
//   Drives PWM waveforms (directed and random) into pwm_demodulator and checks
//   every output on every cycle against an edge-time model: rise/fall edge
//   indices give H and P directly, the duty is plain integer division.
//   CNT_WIDTH is reduced to 12 so stuck-line timeouts stay short.
module tb_pwm_demodulator;
    localparam int CW   = 12;
    localparam int MW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    pwm_demodulator_if #(.CNT_WIDTH(CW), .MOD_WIDTH(MW)) bus ();
    pwm_demodulator #(.CNT_WIDTH(CW), .MOD_WIDTH(MW)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int ovr_cnt = 0;

    // model state
    int   k = 0;
    int   r = 0;
    int   h_cap = 0;
    int   armed = 0;
    int   pend = 0;
    int   dstart = -100;
    int   mq = 0, mh = 0, mp = 0;
    logic lv0 = 1'b0, lv1 = 1'b0, lv2 = 1'b0;
    int   exp_duty = 0, exp_high = 0, exp_period = 0;
    int   exp_valid = 0, exp_busy = 0, exp_timeout = 0, exp_overrun = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        lv0 = 1'b0; lv1 = 1'b0; lv2 = 1'b0;
        r = k; h_cap = 0; armed = 0; pend = 0; dstart = -100;
        exp_duty = 0; exp_high = 0; exp_period = 0;
        exp_valid = 0; exp_busy = 0; exp_timeout = 0; exp_overrun = 0;
    endtask

    // One model step per clock edge; lvl is the pwm_in level sampled there.
    // The input is seen as a rise two edges after it is sampled.
    task automatic model_step(input logic lvl);
        int   c;
        logic rise, fall;
        exp_valid = 0;
        exp_overrun = 0;
        rise = lv1 & ~lv2;
        fall = ~lv1 & lv2;
        c = k - r;
        if (c > MAXC) c = MAXC;
        if (pend != 0 && k == dstart + MW) begin
            exp_duty = mq; exp_high = mh; exp_period = mp; exp_valid = 1; pend = 0;
        end
        if (rise) begin
            if (armed != 0) begin
                if (k <= dstart + MW + 1) begin
                    exp_overrun = 1;
                end else begin
                    dstart = k; pend = 1; mh = h_cap; mp = c;
                    mq = (c > 0) ? ((h_cap << MW) / c) : 0;
                end
            end
            armed = 1; exp_timeout = 0; r = k;
        end else if (armed != 0 && c == MAXC) begin
            exp_timeout = 1; armed = 0; exp_valid = 1;
            exp_duty = lv1 ? ((1 << MW) - 1) : 0;
        end
        if (fall) h_cap = c;
        exp_busy = (pend != 0 && k >= dstart && k <= dstart + MW - 1) ? 1 : 0;
        lv2 = lv1; lv1 = lv0; lv0 = lvl;
    endtask

    // model advance on each active edge
    initial begin
        forever begin
            @(posedge clk);
            k++;
            if (!nrst) model_reset();
            else model_step(bus.pwm_in);
        end
    end

    // per-cycle comparison on the inactive edge
    initial begin
        forever begin
            @(negedge clk);
            if (!nrst) model_reset();
            check("duty",       32'(bus.duty),       32'(exp_duty));
            check("high_cnt",   32'(bus.high_cnt),   32'(exp_high));
            check("period_cnt", 32'(bus.period_cnt), 32'(exp_period));
            check("duty_valid", 32'(bus.duty_valid), 32'(exp_valid));
            check("busy",       32'(bus.busy),       32'(exp_busy));
            check("timeout",    32'(bus.timeout),    32'(exp_timeout));
            check("overrun",    32'(bus.overrun),    32'(exp_overrun));
            if (bus.duty_valid === 1'b1) valid_cnt++;
            if (bus.overrun === 1'b1) ovr_cnt++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic period(input int h, input int p);
        bus.pwm_in = 1'b1;
        wait_cyc(h);
        bus.pwm_in = 1'b0;
        wait_cyc(p - h);
    endtask

    initial begin
        int p, h;
        bus.pwm_in = 1'b0;
        nrst = 1'b0;
        wait_cyc(3);
        nrst = 1'b1;
        wait_cyc(5);

        // 256/64: first rise only arms
        valid_cnt = 0;
        repeat (3) period(64, 256);
        check("t1_valid_count", 32'(valid_cnt), 32'd2);
        check("t1_duty", 32'(bus.duty), 32'd64);
        check("t1_high", 32'(bus.high_cnt), 32'd64);
        check("t1_period", 32'(bus.period_cnt), 32'd256);
        check("t1_model_duty", 32'(exp_duty), 32'd64);

        // 100/33 and 1000/999
        repeat (3) period(33, 100);
        check("t2_duty84", 32'(bus.duty), 32'd84);
        check("t2_high33", 32'(bus.high_cnt), 32'd33);
        check("t2_period100", 32'(bus.period_cnt), 32'd100);
        repeat (2) period(999, 1000);
        check("t2_duty255", 32'(bus.duty), 32'd255);
        check("t2_period1000", 32'(bus.period_cnt), 32'd1000);

        // stuck high
        valid_cnt = 0;
        bus.pwm_in = 1'b1;
        wait_cyc(MAXC + 900);
        check("t3_timeout", 32'(bus.timeout), 32'd1);
        check("t3_duty", 32'(bus.duty), 32'd255);
        check("t3_valid_count", 32'(valid_cnt), 32'd2);
        check("t3_model_timeout", 32'(exp_timeout), 32'd1);
        bus.pwm_in = 1'b0;
        wait_cyc(60);
        valid_cnt = 0;
        period(40, 100);
        check("t3_timeout_cleared", 32'(bus.timeout), 32'd0);
        check("t3_rearm_no_strobe", 32'(valid_cnt), 32'd0);
        period(40, 100);
        check("t3_duty102", 32'(bus.duty), 32'd102);

        // stuck low
        wait_cyc(MAXC + 900);
        check("t4_timeout", 32'(bus.timeout), 32'd1);
        check("t4_duty0", 32'(bus.duty), 32'd0);
        check("t4_high_held", 32'(bus.high_cnt), 32'd40);
        check("t4_period_held", 32'(bus.period_cnt), 32'd100);

        // 6/3 faster than the divider
        valid_cnt = 0;
        ovr_cnt = 0;
        repeat (10) period(3, 6);
        wait_cyc(20);
        check("t5_valid_count", 32'(valid_cnt), 32'd5);
        check("t5_overrun_count", 32'(ovr_cnt), 32'd4);
        check("t5_duty128", 32'(bus.duty), 32'd128);

        // reset during a division
        period(64, 256);
        bus.pwm_in = 1'b1;
        wait_cyc(5);
        check("t6_busy_before_reset", 32'(bus.busy), 32'd1);
        valid_cnt = 0;
        nrst = 1'b0;
        #1;
        check("t6_duty_zero", 32'(bus.duty), 32'd0);
        check("t6_busy_zero", 32'(bus.busy), 32'd0);
        wait_cyc(3);
        nrst = 1'b1;
        wait_cyc(30);
        check("t6_no_strobe", 32'(valid_cnt), 32'd0);
        bus.pwm_in = 1'b0;
        wait_cyc(192);
        repeat (2) period(64, 256);
        check("t6_resumed_duty", 32'(bus.duty), 32'd64);
        check("t6_resumed_period", 32'(bus.period_cnt), 32'd256);

        // random periods, including ones short enough to overrun
        for (int i = 0; i < 150; i++) begin
            p = int'($urandom_range(300, 2));
            h = int'($urandom_range(p - 1, 1));
            period(h, p);
        end
        wait_cyc(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pwm_demodulator.md
Name: pwm_demodulator

Overview:
Receive-side counterpart of the PWM generator. It measures an incoming active-HIGH PWM waveform in system clock cycles and reports raw high time and period. It also reports a normalized MOD_WIDTH-bit duty value, computed by an iterative restoring divider, plus a stuck-line timeout. It is used for loopback checking of PWM outputs and for reading external PWM sensors and fan tachometers.

Parameters:
CNT_WIDTH, 16, width of the high-time and period counters; must be > MOD_WIDTH+1.
MOD_WIDTH, 8, bit width of the normalized duty output.

Ports:
clk  input  1  system clock
nrst  input  1  reset; asynchronous, active-low
pwm_in  input  1  PWM input; asynchronous to clk, active HIGH
duty  output  MOD_WIDTH  duty = floor(high_cnt * 2^MOD_WIDTH / period_cnt)
high_cnt  output  CNT_WIDTH  high time of the last accepted period, in clk cycles
period_cnt  output  CNT_WIDTH  length of the last accepted period, in clk cycles
duty_valid  output  1  one-cycle strobe when duty, high_cnt and period_cnt update
busy  output  1  divider running
timeout  output  1  level; input stuck, no rising edge for 2^CNT_WIDTH-1 cycles
overrun  output  1  one-cycle strobe when a completed period is dropped

Behaviour:
- Reset: all outputs 0. Internal state is cleared: cnt=0, armed=0, FSM=IDLE, synchronizer flops=0.
- Input path:
  - pwm_in passes through a 2-flop synchronizer producing s; p is s delayed one cycle.
  - rise = s & ~p; fall = ~s & p.
  - An input transition is visible on rise/fall 3 clk edges after it occurs.
- Counter cnt:
  - On rise: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at 2^CNT_WIDTH-1.
  - At a rise cycle, cnt equals P, the clock count since the previous rise.
  - At a fall cycle, cnt equals H, the high time.
- On fall: cap_h <= cnt.
- On rise, when armed=1:
  - If FSM=IDLE: latch H=cap_h and P=cnt into the divider, clear the quotient, set bit index = MOD_WIDTH-1, go to DIV.
  - If FSM≠IDLE: the period is dropped and overrun pulses for 1 cycle.
- On rise, unconditionally: armed <= 1 and timeout <= 0. The first rise after reset or timeout only arms and produces no measurement.
- Division range: H < P is guaranteed, so the quotient is in 0..2^MOD_WIDTH-1 and no saturation is needed.
- FSM states:
  - IDLE: busy=0.
  - DIV: busy=1. Restoring step per cycle: rem <= rem*2; if rem*2 >= P, subtract P and set the quotient bit. The remainder starts at H. Width is CNT_WIDTH+1. After MOD_WIDTH cycles go to DONE.
  - DONE: for 1 cycle, duty <= quotient, high_cnt <= H, period_cnt <= P, duty_valid=1; then go to IDLE.
- Latency: duty_valid is asserted MOD_WIDTH+1 cycles after the rise cycle. Minimum loss-free period is MOD_WIDTH+2 cycles; a rise arriving while FSM≠IDLE triggers overrun.
- Timeout: when cnt reaches 2^CNT_WIDTH-1 with no rise and armed=1:
  - timeout <= 1, armed <= 0.
  - duty <= all ones if s=1, else 0.
  - high_cnt and period_cnt are held.
  - duty_valid pulses once.
  - timeout holds until the next rise. The divider cannot be active at this point because CNT_WIDTH > MOD_WIDTH+1.
- Simultaneous events:
  - A fall in the same cycle as DONE does not disturb the outputs; cap_h is independent of the divider operands.
  - A rise in the DONE cycle is an overrun.
- Reset mid-operation: asynchronous nrst deassertion-to-assertion aborts DIV immediately and returns everything to reset values; no duty_valid is produced.

Test Plan:
1. After reset, pwm_in with period 256 and high 64, three periods -> the first rise gives no strobe; then duty=64, high_cnt=64, period_cnt=256, and duty_valid fires exactly 9 cycles after each detected rise.
2. Period 100, high 33 -> duty=84, high_cnt=33, period_cnt=100; period 1000, high 999 -> duty=255.
3. pwm_in held high for 70000 cycles after valid periods -> timeout=1 and duty=255 with one duty_valid at cnt=65535; the next valid period clears timeout, re-arms, and gives no strobe on that rise; the following period is measured.
4. pwm_in held low -> timeout=1, duty=0; high_cnt and period_cnt keep their previous values.
5. Period 6, high 3, repeated -> overrun strobes on alternate rises, accepted periods report duty=128, busy never drops a started division.
6. nrst pulsed low during DIV -> all outputs 0 immediately, no duty_valid; measurement resumes after two rises.
